addr_map_cfg_ctrl: RTL and testbench
====================================

Name: addr_map_cfg_ctrl

Overview:
Configuration controller for the router's logical-to-physical address map. It loads one logical address per physical router index over a valid/ready config stream into a shadow table. On a well-formed load it atomically commits the shadow table, plus a mode bit, to the active packed table consumed by the translation logic. The active table stays stable, and translation keeps running on the old map, while a reload is in progress.

Parameters:
addr_width, 4, width of one logical/physical address
num_routers, 16, number of table entries (physical indices 0..num_routers-1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cfg_start  in  1  pulse: begin a (re)load
cfg_mode  in  1  mode bit, captured on the cfg_start cycle
s_cfg_tvalid  in  1  config beat valid
s_cfg_tready  out  1  config beat ready
s_cfg_tdata  in  addr_width  logical address for physical index = entry_count
s_cfg_tlast  in  1  final beat of the load
table_bits  out  addr_width*num_routers+1  active table: entry i at [i*addr_width +: addr_width]; bit [addr_width*num_routers] = mode
table_valid  out  1  active table holds a committed map
cfg_busy  out  1  load or drain in progress
cfg_done  out  1  one-cycle pulse on commit
cfg_error  out  1  sticky error, cleared by the next cfg_start
cfg_err_code  out  2  0 none, 1 short (early tlast), 2 long (no tlast at last entry), 3 duplicate
entry_count  out  $clog2(num_routers)+1  beats accepted in the current load

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state IDLE; table_bits=0, table_valid=0.
  - cfg_busy, cfg_done, cfg_error, cfg_err_code, entry_count = 0; shadow table = 0.
- States: IDLE, LOAD, DRAIN, COMMIT.
- IDLE: s_cfg_tready=0. Beats are not accepted. cfg_start -> LOAD.
- Entering LOAD (any state except COMMIT, on cfg_start):
  - entry_count=0, shadow cleared, mode captured.
  - cfg_error and cfg_err_code cleared; cfg_busy=1.
  - cfg_start while already in LOAD or DRAIN aborts and restarts the load; the active table is untouched.
- LOAD: s_cfg_tready=1. Each handshake (tvalid & tready) writes shadow[entry_count]=tdata and increments entry_count.
  - tlast with entry_count==num_routers-1 -> COMMIT.
  - tlast with entry_count<num_routers-1 -> IDLE; cfg_error=1, code 1; entry is discarded.
  - Last entry accepted without tlast -> DRAIN; cfg_error=1, code 2.
- DRAIN: s_cfg_tready=1; beats are discarded; entry_count holds. A handshake with tlast -> IDLE.
- COMMIT (exactly one cycle):
  - s_cfg_tready=0; cfg_start is ignored.
  - At the end of the cycle: table_bits = {mode, shadow}, table_valid=1, cfg_done=1 for one cycle, cfg_busy=0, state -> IDLE.
- Latency: final handshake at edge k; new table_bits, table_valid and cfg_done are visible after edge k+1.
- Any error: table_bits and table_valid retain their pre-load values. No partial commit ever occurs.
- cfg_busy=1 in LOAD, DRAIN and COMMIT.
- Reset mid-load: full reset as above; the active table is cleared.
- Simultaneous cfg_start and handshake in LOAD: cfg_start wins and the beat is dropped. A bench must not count that beat.

Optional Feature:
Macro ADDR_MAP_DUP_CHECK_EN.
- Defined:
  - Each accepted beat in LOAD is compared against shadow entries 0..entry_count-1. A match sets an internal dup flag, cleared on load start.
  - At the legal final beat, if dup is set or the final beat itself matches, the load does not commit: -> IDLE, cfg_error=1, code 3.
  - Short/long errors take precedence over duplicate.
- Undefined: no comparison logic is built; code 3 is never produced and duplicate maps commit normally.

Test Plan:
- Reset, then cfg_start with mode=1 and beats 15,14,...,0 with tlast on the 16th -> after edge k+1: table_valid=1, cfg_done one cycle, entry i = 15-i, table_bits[64]=1.
- After the valid map above, load 8 beats with tlast on the 8th -> cfg_error=1, code 1, table_bits unchanged, table_valid=1.
- Load 16 beats without tlast, then 3 extra beats with tlast on the 3rd -> code 2, DRAIN accepts the 3 beats, entry_count=16, table unchanged.
- Load 5 beats, assert cfg_start, then load 16 fresh beats 0..15 -> commit of the fresh identity map; the 5 stale beats are absent.
- ADDR_MAP_DUP_CHECK_EN: beats 0..14 plus final beat 3 -> code 3, no commit. Without the macro, the same stimulus commits with entry15=3.
- Throttled tvalid (1 in 3 cycles) with rst_n=0 mid-load -> all outputs zero the next cycle, state IDLE, tready=0.

Source files
------------

// File: rtl/addr_map_cfg_ctrl.sv
// Address-map configuration controller: streams one logical address per physical index into a
// shadow table and commits it atomically. Optional duplicate detection via ADDR_MAP_DUP_CHECK_EN.
module addr_map_cfg_ctrl #(
    parameter int addr_width  = 4,
    parameter int num_routers = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  cfg_start,
    input  logic                                  cfg_mode,
    input  logic                                  s_cfg_tvalid,
    output logic                                  s_cfg_tready,
    input  logic [addr_width-1:0]                 s_cfg_tdata,
    input  logic                                  s_cfg_tlast,
    output logic [addr_width*num_routers:0]       table_bits,
    output logic                                  table_valid,
    output logic                                  cfg_busy,
    output logic                                  cfg_done,
    output logic                                  cfg_error,
    output logic [1:0]                            cfg_err_code,
    output logic [$clog2(num_routers):0]          entry_count
);

    localparam int CW = $clog2(num_routers) + 1;
    localparam int TW = addr_width * num_routers + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(num_routers - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        COMMIT
    } state_t;

    state_t                                   r_state;
    logic [num_routers-1:0][addr_width-1:0]   r_shadow;
    logic                                     r_mode;
    logic [TW-1:0]                            r_table;
    logic                                     r_valid;
    logic                                     r_done;
    logic                                     r_error;
    logic [1:0]                               r_errCode;
    logic [CW-1:0]                            r_count;

    logic                                     w_beat;
    logic [CW-2:0]                            w_idx;

    assign s_cfg_tready = (r_state == LOAD) || (r_state == DRAIN);
    assign w_beat       = s_cfg_tvalid && s_cfg_tready;
    assign w_idx        = r_count[CW-2:0];

`ifdef ADDR_MAP_DUP_CHECK_EN
    logic r_dup;
    logic w_match;

    // Only entries already written in this load take part in the comparison.
    always_comb begin
        w_match = 1'b0;
        for (int j = 0; j < num_routers; j++) begin
            if ((CW'(j) < r_count) && (r_shadow[j] == s_cfg_tdata)) begin
                w_match = 1'b1;
            end
        end
    end
`endif

    // cfg_start outranks any beat in the same cycle, except during the one-cycle COMMIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shadow  <= '0;
            r_mode    <= 1'b0;
            r_table   <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_errCode <= 2'd0;
            r_count   <= '0;
`ifdef ADDR_MAP_DUP_CHECK_EN
            r_dup     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (cfg_start && (r_state != COMMIT)) begin
                r_state   <= LOAD;
                r_shadow  <= '0;
                r_mode    <= cfg_mode;
                r_error   <= 1'b0;
                r_errCode <= 2'd0;
                r_count   <= '0;
`ifdef ADDR_MAP_DUP_CHECK_EN
                r_dup     <= 1'b0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    LOAD: begin
                        if (w_beat) begin
                            if (s_cfg_tlast && (r_count != LAST_IDX)) begin
                                r_state   <= IDLE;
                                r_error   <= 1'b1;
                                r_errCode <= 2'd1;
                            end else begin
                                r_shadow[w_idx] <= s_cfg_tdata;
                                r_count         <= r_count + CW'(1);
`ifdef ADDR_MAP_DUP_CHECK_EN
                                r_dup           <= r_dup || w_match;
`endif
                                if (r_count == LAST_IDX) begin
                                    if (!s_cfg_tlast) begin
                                        r_state   <= DRAIN;
                                        r_error   <= 1'b1;
                                        r_errCode <= 2'd2;
                                    end else begin
`ifdef ADDR_MAP_DUP_CHECK_EN
                                        if (r_dup || w_match) begin
                                            r_state   <= IDLE;
                                            r_error   <= 1'b1;
                                            r_errCode <= 2'd3;
                                        end else begin
                                            r_state <= COMMIT;
                                        end
`else
                                        r_state <= COMMIT;
`endif
                                    end
                                end
                            end
                        end
                    end
                    DRAIN: begin
                        if (w_beat && s_cfg_tlast) begin
                            r_state <= IDLE;
                        end
                    end
                    COMMIT: begin
                        r_table <= {r_mode, r_shadow};
                        r_valid <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign table_bits   = r_table;
    assign table_valid  = r_valid;
    assign cfg_busy     = (r_state != IDLE);
    assign cfg_done     = r_done;
    assign cfg_error    = r_error;
    assign cfg_err_code = r_errCode;
    assign entry_count  = r_count;

endmodule

// File: tb/tb_addr_map_cfg_ctrl.sv
// Randomized self-checking bench for addr_map_cfg_ctrl; the reference model judges each whole
// load from its beat list. Honours ADDR_MAP_DUP_CHECK_EN when the build defines it.
module tb_addr_map_cfg_ctrl;

    localparam int W  = 4;
    localparam int N  = 16;
    localparam int TW = W * N + 1;
    localparam int CW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_start;
    logic          cfg_mode;
    logic          s_cfg_tvalid;
    logic          s_cfg_tready;
    logic [W-1:0]  s_cfg_tdata;
    logic          s_cfg_tlast;
    logic [TW-1:0] table_bits;
    logic          table_valid;
    logic          cfg_busy;
    logic          cfg_done;
    logic          cfg_error;
    logic [1:0]    cfg_err_code;
    logic [CW-1:0] entry_count;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [W-1:0] beatData[$];
    bit           beatLast[$];

    logic [W-1:0] mTable[N];
    bit           mMode;
    bit           mValid;

    always #5 clk = ~clk;

    addr_map_cfg_ctrl #(.addr_width(W), .num_routers(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_mode     (cfg_mode),
        .s_cfg_tvalid (s_cfg_tvalid),
        .s_cfg_tready (s_cfg_tready),
        .s_cfg_tdata  (s_cfg_tdata),
        .s_cfg_tlast  (s_cfg_tlast),
        .table_bits   (table_bits),
        .table_valid  (table_valid),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .cfg_error    (cfg_error),
        .cfg_err_code (cfg_err_code),
        .entry_count  (entry_count)
    );

    task automatic checkOutput(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] modelBits();
        logic [TW-1:0] b = '0;
        for (int i = 0; i < N; i++) b[i*W +: W] = mTable[i];
        b[TW-1] = mMode;
        return b;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < N; i++) mTable[i] = '0;
        mMode  = 1'b0;
        mValid = 1'b0;
    endfunction

    // Judge a complete load: where the first tlast sits decides short/long/legal.
    task automatic modelLoad(input bit mode, output int code, output bit commit);
        int  t   = -1;
        bit  dup = 1'b0;
        commit = 1'b0;
        for (int i = 0; i < beatData.size(); i++) begin
            if (beatLast[i] && t < 0) t = i;
        end
        if (t >= 0 && t < N - 1) begin
            code = 1;
        end else if (t != N - 1) begin
            code = 2;
        end else begin
`ifdef ADDR_MAP_DUP_CHECK_EN
            for (int i = 0; i < N; i++)
                for (int j = 0; j < i; j++)
                    if (beatData[i] == beatData[j]) dup = 1'b1;
`endif
            if (dup) begin
                code = 3;
            end else begin
                code   = 0;
                commit = 1'b1;
                for (int i = 0; i < N; i++) mTable[i] = beatData[i];
                mMode  = mode;
                mValid = 1'b1;
            end
        end
    endtask

    task automatic startLoad(input bit mode, input bit junk);
        @(negedge clk);
        cfg_start    = 1'b1;
        cfg_mode     = mode;
        s_cfg_tvalid = junk;
        s_cfg_tdata  = W'($urandom_range(15, 0));
        s_cfg_tlast  = 1'b0;
        @(negedge clk);
        cfg_start    = 1'b0;
        s_cfg_tvalid = 1'b0;
        checkOutput("busyAfterStart", TW'(cfg_busy), TW'(1));
        checkOutput("countAfterStart", TW'(entry_count), TW'(0));
        checkOutput("errorAfterStart", TW'(cfg_error), TW'(0));
    endtask

    task automatic sendBeats(input int gapMax);
        for (int i = 0; i < beatData.size(); i++) begin
            int gap = $urandom_range(gapMax, 0);
            repeat (gap) @(negedge clk);
            if (i == 0) checkOutput("treadyInLoad", TW'(s_cfg_tready), TW'(1));
            s_cfg_tvalid = 1'b1;
            s_cfg_tdata  = beatData[i];
            s_cfg_tlast  = beatLast[i];
            @(negedge clk);
            s_cfg_tvalid = 1'b0;
            s_cfg_tlast  = 1'b0;
        end
    endtask

    // kind 0: legal length, 1: short, 2: long with drain; perm makes legal data duplicate-free.
    task automatic buildBeats(input int kind, input bit perm);
        int len;
        beatData.delete();
        beatLast.delete();
        len = (kind == 0) ? N : (kind == 1) ? int'($urandom_range(N - 1, 1)) : N + int'($urandom_range(3, 1));
        for (int i = 0; i < len; i++) begin
            beatData.push_back(perm && i < N ? W'(i) : W'($urandom_range(15, 0)));
            beatLast.push_back(i == len - 1);
        end
        if (perm) begin
            for (int i = N - 1; i > 0; i--) begin
                int j = $urandom_range(i, 0);
                logic [W-1:0] tmp = beatData[i];
                beatData[i] = beatData[j];
                beatData[j] = tmp;
            end
        end
    endtask

    task automatic applyStimulus(input bit mode, input int gapMax, input bit junk);
        int code;
        bit commit;
        startLoad(mode, junk);
        sendBeats(gapMax);
        modelLoad(mode, code, commit);
        if (commit) begin
            checkOutput("doneNotYet", TW'(cfg_done), TW'(0));
            checkOutput("busyInCommit", TW'(cfg_busy), TW'(1));
            checkOutput("tableHeldInCommit", table_bits, TW'(0) | (table_bits));
            @(negedge clk);
            checkOutput("donePulse", TW'(cfg_done), TW'(1));
            checkOutput("tableCommitted", table_bits, modelBits());
            checkOutput("validCommitted", TW'(table_valid), TW'(1));
            checkOutput("busyAfterCommit", TW'(cfg_busy), TW'(0));
            checkOutput("errorAfterCommit", TW'(cfg_error), TW'(0));
            checkOutput("countAfterCommit", TW'(entry_count), TW'(N));
            @(negedge clk);
            checkOutput("doneOneCycle", TW'(cfg_done), TW'(0));
        end else begin
            checkOutput("errorFlag", TW'(cfg_error), TW'(1));
            checkOutput("errorCode", TW'(cfg_err_code), TW'(code));
            checkOutput("busyAfterError", TW'(cfg_busy), TW'(0));
            checkOutput("noDoneOnError", TW'(cfg_done), TW'(0));
            checkOutput("tableKept", table_bits, modelBits());
            checkOutput("validKept", TW'(table_valid), TW'(mValid));
            if (code == 2) checkOutput("countAfterDrain", TW'(entry_count), TW'(N));
            @(negedge clk);
            checkOutput("errorSticky", TW'(cfg_error), TW'(1));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Table"}, table_bits, TW'(0));
        checkOutput({tag, "Valid"}, TW'(table_valid), TW'(0));
        checkOutput({tag, "Busy"}, TW'(cfg_busy), TW'(0));
        checkOutput({tag, "Done"}, TW'(cfg_done), TW'(0));
        checkOutput({tag, "Error"}, TW'(cfg_error), TW'(0));
        checkOutput({tag, "Code"}, TW'(cfg_err_code), TW'(0));
        checkOutput({tag, "Count"}, TW'(entry_count), TW'(0));
        checkOutput({tag, "Tready"}, TW'(s_cfg_tready), TW'(0));
    endtask

    initial begin
        rst_n        = 1'b0;
        cfg_start    = 1'b0;
        cfg_mode     = 1'b0;
        s_cfg_tvalid = 1'b0;
        s_cfg_tdata  = '0;
        s_cfg_tlast  = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkAllZero("reset");

        // Descending map with mode set.
        beatData.delete();
        beatLast.delete();
        for (int i = 0; i < N; i++) begin
            beatData.push_back(W'(N - 1 - i));
            beatLast.push_back(i == N - 1);
        end
        applyStimulus(1'b1, 0, 1'b0);
        checkOutput("modeBit", TW'(table_bits[TW-1]), TW'(1));
        checkOutput("entry0", TW'(table_bits[0 +: W]), TW'(15));

        // Short load of 8, then long load of 16 + 3 drained beats.
        buildBeats(1, 1'b0);
        while (beatData.size() != 8) buildBeats(1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);
        beatData.delete();
        beatLast.delete();
        for (int i = 0; i < N + 3; i++) begin
            beatData.push_back(W'(i));
            beatLast.push_back(i == N + 2);
        end
        applyStimulus(1'b0, 0, 1'b0);

        // Aborted load of 5 beats, restarted by a cfg_start that also carries a dropped beat.
        buildBeats(0, 1'b0);
        beatData = beatData[0:4];
        beatLast = beatLast[0:4];
        beatLast[4] = 1'b0;
        startLoad(1'b1, 1'b0);
        sendBeats(0);
        beatData.delete();
        beatLast.delete();
        for (int i = 0; i < N; i++) begin
            beatData.push_back(W'(i));
            beatLast.push_back(i == N - 1);
        end
        applyStimulus(1'b0, 0, 1'b1);

        // Duplicate final entry: rejected with the check built in, committed without it.
        beatData[N-1] = W'(3);
        applyStimulus(1'b1, 1, 1'b0);

        for (int k = 0; k < 24; k++) begin
            buildBeats($urandom_range(2, 0), bit'($urandom_range(1, 0)));
            applyStimulus(bit'($urandom_range(1, 0)), $urandom_range(2, 0), bit'($urandom_range(1, 0)));
        end

        // Throttled load interrupted by reset.
        buildBeats(0, 1'b1);
        beatData = beatData[0:5];
        beatLast = beatLast[0:5];
        startLoad(1'b1, 1'b0);
        sendBeats(2);
        rst_n = 1'b0;
        @(negedge clk);
        modelReset();
        checkAllZero("midReset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
